// File: rtl/algo_queue_pkg.sv
// algo_queue_pkg: shared sizing, pointer/count types and ring FSM states for the multi-port queue ring.
package algo_queue_pkg;
  localparam int NUMQUEU = 8;
  localparam int BITQUEU = 3;
  localparam int NUMDPTH = 16;
  localparam int BITDPTH = 4;
  localparam int WIDTH   = 13;
  localparam int NUMPUPT = 4;
  localparam int NUMPOPT = 2;
  localparam int AFULTHR = 12;
  localparam int BITCNT  = BITDPTH + 1;
  typedef logic [BITDPTH-1:0] q_ptr_t;
  typedef logic [BITCNT-1:0]  q_cnt_t;
  typedef enum logic {INIT, RUN} ring_st_t;
endpackage

// File: rtl/algo_mrnw_queue_ring_rank.sv
// queue_rank_arb: rank of each requesting port among lower-indexed ports targeting the same queue.
module queue_rank_arb #(
  parameter int N  = 4,
  parameter int BQ = 3,
  parameter int RW = 3
) (
  input  logic [N-1:0]         req_i,
  input  logic [N*BQ-1:0]      adr_i,
  output logic [N-1:0][RW-1:0] rank_o
);
  always_comb begin
    for (int p = 0; p < N; p++) begin
      rank_o[p] = '0;
      for (int j = 0; j < p; j++)
        rank_o[p] = rank_o[p] + RW'(req_i[j] && adr_i[j*BQ +: BQ] == adr_i[p*BQ +: BQ]);
    end
  end
endmodule

// File: rtl/algo_mrnw_queue_ring.sv
// algo_mrnw_queue_ring: NUMQUEU flop-based ring FIFOs served by NUMPUPT push and NUMPOPT pop ports per cycle,
// with per-queue occupancy, almost-full, flush and drop-on-full reporting.
module algo_mrnw_queue_ring
  import algo_queue_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        ready_o,
  input  logic [NUMPUPT-1:0]          push_i,
  input  logic [NUMPUPT*BITQUEU-1:0]  pu_adr_i,
  input  logic [NUMPUPT*WIDTH-1:0]    pu_din_i,
  output logic [NUMPUPT-1:0]          pu_drop_o,
  input  logic [NUMPOPT-1:0]          pop_i,
  input  logic [NUMPOPT*BITQUEU-1:0]  po_adr_i,
  output logic [NUMPOPT-1:0]          po_vld_o,
  output logic [NUMPOPT*WIDTH-1:0]    po_dout_o,
  input  logic                        flush_i,
  input  logic [BITQUEU-1:0]          fl_adr_i,
  output logic [NUMQUEU*BITCNT-1:0]   q_cnt_o,
  output logic [NUMQUEU-1:0]          q_afull_o
);
  localparam int PUW = $clog2(NUMPUPT) + 1;
  localparam int POW = $clog2(NUMPOPT) + 1;
  localparam int FW  = BITCNT + 1;
  ring_st_t st_q, st_d;
  logic [BITQUEU-1:0] init_q, init_d;
  q_ptr_t head_q [NUMQUEU], head_d [NUMQUEU], tail_q [NUMQUEU], tail_d [NUMQUEU];
  q_cnt_t cnt_q [NUMQUEU], cnt_d [NUMQUEU];
  logic [WIDTH-1:0] mem_q [NUMQUEU][NUMDPTH];
  logic [NUMPUPT-1:0][PUW-1:0] pu_rank;
  logic [NUMPOPT-1:0][POW-1:0] po_rank;
  logic [BITQUEU-1:0] pu_q [NUMPUPT], po_q [NUMPOPT];
  logic [POW-1:0] served [NUMQUEU];
  logic [PUW-1:0] accn [NUMQUEU];
  logic [FW-1:0] qfree [NUMQUEU];
  logic [NUMPUPT-1:0] pu_acc, pu_drop_d;
  logic [NUMPOPT-1:0] po_vld_d;
  logic [NUMPOPT*WIDTH-1:0] po_dout_d;
  logic [NUMQUEU-1:0] afull_d;
  logic run;
  assign run = st_q == RUN;
  assign ready_o = run;
  queue_rank_arb #(.N(NUMPUPT), .BQ(BITQUEU), .RW(PUW)) u_pu_rank (
    .req_i(push_i), .adr_i(pu_adr_i), .rank_o(pu_rank));
  queue_rank_arb #(.N(NUMPOPT), .BQ(BITQUEU), .RW(POW)) u_po_rank (
    .req_i(pop_i), .adr_i(po_adr_i), .rank_o(po_rank));
  always_comb begin
    st_d = st_q;
    init_d = init_q;
    if (st_q == INIT) begin
      init_d = init_q + 1'b1;
      st_d = init_q == BITQUEU'(NUMQUEU - 1) ? RUN : INIT;
    end
  end
  // Pops see only the start-of-cycle count, so a same-cycle push can never be popped.
  always_comb begin
    po_dout_d = '0;
    for (int p = 0; p < NUMPOPT; p++) begin
      po_q[p] = po_adr_i[p*BITQUEU +: BITQUEU];
      po_vld_d[p] = run && pop_i[p] && !(flush_i && fl_adr_i == po_q[p])
                    && q_cnt_t'(po_rank[p]) < cnt_q[po_q[p]];
      po_dout_d[p*WIDTH +: WIDTH] = po_vld_d[p] ? mem_q[po_q[p]][head_q[po_q[p]] + q_ptr_t'(po_rank[p])] : '0;
    end
  end
  always_comb begin
    for (int q = 0; q < NUMQUEU; q++) begin
      served[q] = '0;
      for (int p = 0; p < NUMPOPT; p++)
        served[q] = served[q] + POW'(po_vld_d[p] && po_q[p] == BITQUEU'(q));
      qfree[q] = FW'(NUMDPTH) - FW'(cnt_q[q]) + FW'(served[q]);
    end
    for (int p = 0; p < NUMPUPT; p++) begin
      pu_q[p] = pu_adr_i[p*BITQUEU +: BITQUEU];
      pu_acc[p] = run && push_i[p] && !(flush_i && fl_adr_i == pu_q[p]) && FW'(pu_rank[p]) < qfree[pu_q[p]];
      pu_drop_d[p] = run && push_i[p] && !(flush_i && fl_adr_i == pu_q[p]) && !pu_acc[p];
    end
    for (int q = 0; q < NUMQUEU; q++) begin
      accn[q] = '0;
      for (int p = 0; p < NUMPUPT; p++)
        accn[q] = accn[q] + PUW'(pu_acc[p] && pu_q[p] == BITQUEU'(q));
      head_d[q] = head_q[q] + q_ptr_t'(served[q]);
      tail_d[q] = tail_q[q] + q_ptr_t'(accn[q]);
      cnt_d[q] = cnt_q[q] - q_cnt_t'(served[q]) + q_cnt_t'(accn[q]);
      if ((run && flush_i && fl_adr_i == BITQUEU'(q)) || (!run && init_q == BITQUEU'(q))) begin
        head_d[q] = '0;
        tail_d[q] = '0;
        cnt_d[q] = '0;
      end
      afull_d[q] = cnt_d[q] >= q_cnt_t'(AFULTHR);
      q_cnt_o[q*BITCNT +: BITCNT] = cnt_q[q];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= INIT;
      init_q <= '0;
      for (int q = 0; q < NUMQUEU; q++) begin
        head_q[q] <= '0;
        tail_q[q] <= '0;
        cnt_q[q] <= '0;
      end
      pu_drop_o <= '0;
      po_vld_o <= '0;
      po_dout_o <= '0;
      q_afull_o <= '0;
    end else begin
      st_q <= st_d;
      init_q <= init_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
      pu_drop_o <= pu_drop_d;
      po_vld_o <= po_vld_d;
      po_dout_o <= po_dout_d;
      q_afull_o <= afull_d;
    end
  end
  // Data storage is never reset; validity is tracked purely by head/tail/count.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUMPUPT; p++)
      if (pu_acc[p]) mem_q[pu_q[p]][tail_q[pu_q[p]] + q_ptr_t'(pu_rank[p])] <= pu_din_i[p*WIDTH +: WIDTH];
  end
endmodule
